// File: rtl/dog_draw_ctl.sv
// Dog sprite overlay: vsync-paced walk animation plus a 3-stage pixel pipeline
// that addresses the frame ROMs and composites the sprite over the background.
module dog_draw_ctl #(
  parameter int unsigned FRAME_DIV       = 8,
  parameter logic [11:0] TRANSPARENT_RGB = 12'hF0F
) (
  input  logic        clk60MHz,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        moving,
  output logic [11:0] rom_addr,
  input  logic [11:0] rom_rgb0,
  input  logic [11:0] rom_rgb1,
  input  logic [11:0] rom_rgb2,
  input  logic [11:0] rom_rgb3,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic [1:0]  anim_frame
);

  localparam int unsigned CW      = 11;
  localparam int unsigned PW      = 12;
  localparam int unsigned HW      = 13;
  localparam int unsigned SPR_DIM = 64;

  typedef enum logic {IDLE, WALK} state_t;

  typedef struct packed {
    logic [CW-1:0] hc;
    logic [CW-1:0] vc;
    logic          hs;
    logic          vs;
    logic          hb;
    logic          vb;
    logic [PW-1:0] rgb;
    logic          hit;
    logic [1:0]    frame;
  } side_t;

  state_t        state_q;
  logic [7:0]    div_q;
  logic [1:0]    frame_q;
  logic          vsync_q;
  logic [PW-1:0] pos_x_q;
  logic [PW-1:0] pos_y_q;
  side_t         s1_q;
  side_t         s2_q;
  side_t         out_q;
  logic [PW-1:0] rom_addr_q;
  logic [PW-1:0] rgb_out_q;

  logic          tick_c;
  logic          hit_c;
  logic [5:0]    dx_c;
  logic [5:0]    dy_c;
  logic [PW-1:0] rom_pix_c;

  assign tick_c = vsync_in & ~vsync_q;

  // Window test in 13 bits so a sprite near the 12-bit limit never wraps to 0.
  always_comb begin
    hit_c = (HW'(hcount_in) >= HW'(pos_x_q)) &&
            (HW'(hcount_in) <  HW'(pos_x_q) + HW'(SPR_DIM)) &&
            (HW'(vcount_in) >= HW'(pos_y_q)) &&
            (HW'(vcount_in) <  HW'(pos_y_q) + HW'(SPR_DIM));
    dx_c  = hcount_in[5:0] - pos_x_q[5:0];
    dy_c  = vcount_in[5:0] - pos_y_q[5:0];
  end

  always_comb begin
    rom_pix_c = rom_rgb0;
    case (s2_q.frame)
      2'd1:    rom_pix_c = rom_rgb1;
      2'd2:    rom_pix_c = rom_rgb2;
      2'd3:    rom_pix_c = rom_rgb3;
      default: rom_pix_c = rom_rgb0;
    endcase
  end

  // Animation FSM and position latch, both advanced only on a frame tick.
  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      frame_q <= '0;
      vsync_q <= 1'b0;
      pos_x_q <= '0;
      pos_y_q <= '0;
    end else begin
      vsync_q <= vsync_in;
      if (tick_c) begin
        pos_x_q <= xpos;
        pos_y_q <= ypos;
        case (state_q)
          IDLE: begin
            div_q   <= '0;
            frame_q <= '0;
            if (moving) state_q <= WALK;
          end
          WALK: begin
            if (!moving) begin
              state_q <= IDLE;
              div_q   <= '0;
              frame_q <= '0;
            end else if (div_q == 8'(FRAME_DIV - 1)) begin
              div_q   <= '0;
              frame_q <= frame_q + 2'd1;
            end else begin
              div_q <= div_q + 8'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Pixel pipeline: stage 1 addresses ROM, stage 2 waits for data, stage 3 mixes.
  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      out_q      <= '0;
      rom_addr_q <= '0;
      rgb_out_q  <= '0;
    end else begin
      s1_q.hc    <= hcount_in;
      s1_q.vc    <= vcount_in;
      s1_q.hs    <= hsync_in;
      s1_q.vs    <= vsync_in;
      s1_q.hb    <= hblnk_in;
      s1_q.vb    <= vblnk_in;
      s1_q.rgb   <= rgb_in;
      s1_q.hit   <= hit_c;
      s1_q.frame <= frame_q;
      rom_addr_q <= hit_c ? {dy_c, dx_c} : '0;
      s2_q       <= s1_q;
      out_q      <= s2_q;
      if (s2_q.hb || s2_q.vb)
        rgb_out_q <= '0;
      else if (s2_q.hit && (rom_pix_c != TRANSPARENT_RGB))
        rgb_out_q <= rom_pix_c;
      else
        rgb_out_q <= s2_q.rgb;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign hcount_out = out_q.hc;
  assign vcount_out = out_q.vc;
  assign hsync_out  = out_q.hs;
  assign vsync_out  = out_q.vs;
  assign hblnk_out  = out_q.hb;
  assign vblnk_out  = out_q.vb;
  assign rgb_out    = rgb_out_q;
  assign anim_frame = frame_q;

endmodule

// File: tb/tb_dog_draw_ctl.sv
// Directed bench for dog_draw_ctl: reset, pipeline latency, compositing,
// clipping, tear-free position latch and the walk animation sequence.
module tb_dog_draw_ctl;

  logic        clk60MHz = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in, xpos, ypos;
  logic        moving;
  logic [11:0] rom_addr;
  logic [11:0] rom_rgb0, rom_rgb1, rom_rgb2, rom_rgb3;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic [1:0]  anim_frame;

  int checks = 0;
  int errors = 0;

  always #8 clk60MHz = ~clk60MHz;

  dog_draw_ctl #(.FRAME_DIV(2), .TRANSPARENT_RGB(12'hF0F)) dut (
    .clk60MHz  (clk60MHz),
    .rst       (rst),
    .hcount_in (hcount_in),
    .vcount_in (vcount_in),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .hblnk_in  (hblnk_in),
    .vblnk_in  (vblnk_in),
    .rgb_in    (rgb_in),
    .xpos      (xpos),
    .ypos      (ypos),
    .moving    (moving),
    .rom_addr  (rom_addr),
    .rom_rgb0  (rom_rgb0),
    .rom_rgb1  (rom_rgb1),
    .rom_rgb2  (rom_rgb2),
    .rom_rgb3  (rom_rgb3),
    .hcount_out(hcount_out),
    .vcount_out(vcount_out),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out),
    .hblnk_out (hblnk_out),
    .vblnk_out (vblnk_out),
    .rgb_out   (rgb_out),
    .anim_frame(anim_frame)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk60MHz);
    #1;
  endtask

  task automatic set_px(input logic [10:0] h, input logic [10:0] v, input logic [11:0] rgb,
                        input logic hb, input logic vb);
    hcount_in = h;
    vcount_in = v;
    rgb_in    = rgb;
    hblnk_in  = hb;
    vblnk_in  = vb;
  endtask

  // Hold one pixel long enough for it to reach the outputs.
  task automatic run_px(input logic [10:0] h, input logic [10:0] v, input logic [11:0] rgb,
                        input logic hb, input logic vb);
    set_px(h, v, rgb, hb, vb);
    repeat (3) step();
  endtask

  task automatic frame_tick();
    vsync_in = 1'b1;
    step();
    vsync_in = 1'b0;
    step();
  endtask

  logic [1:0] walk_seq [9];

  initial begin
    walk_seq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};

    // Reset with random inputs
    rst       = 1'b1;
    hcount_in = 11'($urandom);
    vcount_in = 11'($urandom);
    hsync_in  = 1'($urandom);
    vsync_in  = 1'($urandom);
    hblnk_in  = 1'($urandom);
    vblnk_in  = 1'($urandom);
    rgb_in    = 12'($urandom);
    xpos      = 12'($urandom);
    ypos      = 12'($urandom);
    moving    = 1'($urandom);
    rom_rgb0  = 12'($urandom);
    rom_rgb1  = 12'($urandom);
    rom_rgb2  = 12'($urandom);
    rom_rgb3  = 12'($urandom);
    step();
    check_eq("rst_rgb_out", 32'(rgb_out), 32'h0);
    check_eq("rst_rom_addr", 32'(rom_addr), 32'h0);
    check_eq("rst_hcount", 32'(hcount_out), 32'h0);
    check_eq("rst_vcount", 32'(vcount_out), 32'h0);
    check_eq("rst_flags", 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'h0);
    check_eq("rst_frame", 32'(anim_frame), 32'h0);
    step();
    rst = 1'b0;
    set_px(11'd0, 11'd0, 12'h000, 1'b0, 1'b0);
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    moving   = 1'b0;
    rom_rgb0 = 12'h000;
    rom_rgb1 = 12'h000;
    rom_rgb2 = 12'h000;
    rom_rgb3 = 12'h000;
    xpos     = 12'd100;
    ypos     = 12'd50;
    step();
    frame_tick();
    check_eq("idle_frame", 32'(anim_frame), 32'h0);

    // Latency: single pixel pulse followed by a miss pixel
    set_px(11'd110, 11'd60, 12'h777, 1'b0, 1'b0);
    step();
    check_eq("lat_rom_addr", 32'(rom_addr), 32'h28A);
    set_px(11'd0, 11'd0, 12'h555, 1'b0, 1'b0);
    step();
    check_eq("lat_rom_addr_miss", 32'(rom_addr), 32'h0);
    rom_rgb0 = 12'h123;
    step();
    check_eq("lat_rgb_out", 32'(rgb_out), 32'h123);
    check_eq("lat_hcount", 32'(hcount_out), 32'd110);
    check_eq("lat_vcount", 32'(vcount_out), 32'd60);
    step();
    check_eq("lat_next_hcount", 32'(hcount_out), 32'd0);
    check_eq("lat_next_rgb", 32'(rgb_out), 32'h555);

    // Transparency, clipping and blanking
    rom_rgb0 = 12'hF0F;
    run_px(11'd110, 11'd60, 12'hABC, 1'b0, 1'b0);
    check_eq("transparent", 32'(rgb_out), 32'hABC);
    rom_rgb0 = 12'h123;
    run_px(11'd164, 11'd60, 12'hABC, 1'b0, 1'b0);
    check_eq("clip_right_rgb", 32'(rgb_out), 32'hABC);
    check_eq("clip_right_addr", 32'(rom_addr), 32'h0);
    run_px(11'd163, 11'd60, 12'hABC, 1'b0, 1'b0);
    check_eq("last_col_addr", 32'(rom_addr), 32'h2BF);
    check_eq("last_col_rgb", 32'(rgb_out), 32'h123);
    run_px(11'd110, 11'd113, 12'hABC, 1'b0, 1'b0);
    check_eq("last_row_addr", 32'(rom_addr), 32'hFCA);
    run_px(11'd110, 11'd114, 12'hABC, 1'b0, 1'b0);
    check_eq("clip_bottom_rgb", 32'(rgb_out), 32'hABC);
    run_px(11'd99, 11'd60, 12'hABC, 1'b0, 1'b0);
    check_eq("left_miss_rgb", 32'(rgb_out), 32'hABC);
    run_px(11'd110, 11'd60, 12'hABC, 1'b1, 1'b0);
    check_eq("hblnk_rgb", 32'(rgb_out), 32'h0);
    check_eq("hblnk_flag", 32'(hblnk_out), 32'h1);
    run_px(11'd0, 11'd0, 12'hABC, 1'b0, 1'b1);
    check_eq("vblnk_rgb", 32'(rgb_out), 32'h0);

    // Position only moves on a vsync rising edge
    xpos = 12'd500;
    run_px(11'd110, 11'd60, 12'hABC, 1'b0, 1'b0);
    check_eq("tear_old_pos", 32'(rom_addr), 32'h28A);
    frame_tick();
    run_px(11'd110, 11'd60, 12'hABC, 1'b0, 1'b0);
    check_eq("tear_old_gone", 32'(rgb_out), 32'hABC);
    run_px(11'd510, 11'd60, 12'hABC, 1'b0, 1'b0);
    check_eq("tear_new_pos", 32'(rom_addr), 32'h28A);

    // Origin placement
    xpos = 12'd0;
    ypos = 12'd0;
    frame_tick();
    rom_rgb0 = 12'h456;
    run_px(11'd0, 11'd0, 12'hABC, 1'b0, 1'b0);
    check_eq("origin_rgb", 32'(rgb_out), 32'h456);
    run_px(11'd63, 11'd63, 12'hABC, 1'b0, 1'b0);
    check_eq("origin_corner_addr", 32'(rom_addr), 32'hFFF);

    // Far off-screen and near the 12-bit limit: no hit, no wrap
    xpos = 12'd2000;
    frame_tick();
    run_px(11'd1023, 11'd10, 12'hABC, 1'b0, 1'b0);
    check_eq("far_x_rgb", 32'(rgb_out), 32'hABC);
    xpos = 12'd4090;
    frame_tick();
    run_px(11'd10, 11'd10, 12'hABC, 1'b0, 1'b0);
    check_eq("nowrap_addr", 32'(rom_addr), 32'h0);
    check_eq("nowrap_rgb", 32'(rgb_out), 32'hABC);

    // Walk animation with FRAME_DIV=2
    xpos     = 12'd100;
    ypos     = 12'd50;
    rom_rgb0 = 12'h111;
    rom_rgb1 = 12'h222;
    rom_rgb2 = 12'h333;
    rom_rgb3 = 12'h444;
    moving   = 1'b1;
    for (int i = 0; i < 9; i++) begin
      frame_tick();
      check_eq($sformatf("walk_seq%0d", i), 32'(anim_frame), 32'(walk_seq[i]));
    end
    frame_tick();
    frame_tick();
    check_eq("walk_frame1", 32'(anim_frame), 32'h1);
    run_px(11'd110, 11'd60, 12'hABC, 1'b0, 1'b0);
    check_eq("frame1_rom_sel", 32'(rgb_out), 32'h222);
    frame_tick();
    frame_tick();
    frame_tick();
    check_eq("walk_frame2", 32'(anim_frame), 32'h2);
    moving = 1'b0;
    frame_tick();
    check_eq("stop_frame", 32'(anim_frame), 32'h0);
    run_px(11'd110, 11'd60, 12'hABC, 1'b0, 1'b0);
    check_eq("stop_rom_sel", 32'(rgb_out), 32'h111);
    frame_tick();
    check_eq("idle_hold", 32'(anim_frame), 32'h0);
    moving = 1'b1;
    frame_tick();
    check_eq("rewalk_t0", 32'(anim_frame), 32'h0);
    frame_tick();
    check_eq("rewalk_t1", 32'(anim_frame), 32'h0);
    frame_tick();
    check_eq("rewalk_t2", 32'(anim_frame), 32'h1);

    // Mid-frame reset takes effect in one clock
    set_px(11'd110, 11'd60, 12'hABC, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    check_eq("midrst_frame", 32'(anim_frame), 32'h0);
    check_eq("midrst_addr", 32'(rom_addr), 32'h0);
    check_eq("midrst_hcount", 32'(hcount_out), 32'h0);
    rst    = 1'b0;
    moving = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
